// File: rtl/unidade_controle.sv
// Multicycle control FSM feeding the 3:1 accumulator-source mux: fetches opcode and
// immediate bytes over a req/ack handshake, decodes them and issues load strobes.
module unidade_controle #(
  parameter int LARGURA_END    = 8,
  parameter int TIMEOUT_CICLOS = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iniciar,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_dado,
  output logic                   mem_req,
  output logic [LARGURA_END-1:0] mem_end,
  output logic [1:0]             selecao,
  output logic [7:0]             imediato,
  output logic                   carrega_acc,
  output logic                   carrega_reg,
  output logic [1:0]             reg_end,
  output logic [2:0]             ula_op,
  output logic                   ocupado,
  output logic                   parado,
  output logic                   erro
);

  typedef enum logic [2:0] {
    OCIOSO, BUSCA, DECODIFICA, BUSCA_IMED, EXECUTA, ESCRITA, PARADO
  } estado_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_ULA = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam int              LARG_CNT = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [LARG_CNT-1:0] CNT_MAX = LARG_CNT'(TIMEOUT_CICLOS - 1);

  estado_t               estado, estado_n;
  logic [LARGURA_END-1:0] pc;
  logic [7:0]            ir;
  logic [LARG_CNT-1:0]   cnt;
  logic                  ilegal, timeout, busca_atual;
  logic [1:0]            sel_n;
  logic                  acc_n, reg_n;

  assign mem_end     = pc;
  assign busca_atual = (estado == BUSCA) || (estado == BUSCA_IMED);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    estado_n = estado;
    ilegal   = 1'b0;
    timeout  = 1'b0;
    unique case (estado)
      OCIOSO:     if (iniciar) estado_n = BUSCA;
      BUSCA, BUSCA_IMED: begin
        if (mem_ack) begin
          if (estado == BUSCA) estado_n = DECODIFICA;
          else                 estado_n = ESCRITA;
        end else if (cnt == CNT_MAX) begin
          estado_n = PARADO;
          timeout  = 1'b1;
        end
      end
      DECODIFICA: begin
        case (ir[7:5])
          OP_NOP:                 estado_n = BUSCA;
          OP_LDI:                 estado_n = BUSCA_IMED;
          OP_MOV, OP_ULA, OP_STR: estado_n = EXECUTA;
          OP_HLT:                 estado_n = PARADO;
          default: begin
            estado_n = PARADO;
            ilegal   = 1'b1;
          end
        endcase
      end
      EXECUTA:    estado_n = ESCRITA;
      ESCRITA:    estado_n = BUSCA;
      PARADO:     estado_n = PARADO;
      default:    estado_n = OCIOSO;
    endcase
  end

  // Write-back decode: which mux input is loaded and which strobe fires in ESCRITA.
  always_comb begin
    sel_n = 2'b11;
    acc_n = 1'b0;
    reg_n = 1'b0;
    if (estado_n == ESCRITA) begin
      case (ir[7:5])
        OP_LDI:  begin sel_n = 2'b10; acc_n = 1'b1; end
        OP_MOV:  begin sel_n = 2'b01; acc_n = 1'b1; end
        OP_ULA:  begin sel_n = 2'b00; acc_n = 1'b1; end
        OP_STR:  reg_n = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: outputs are registered from estado_n, so each is already valid in the cycle its state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      pc          <= '0;
      ir          <= '0;
      cnt         <= '0;
      imediato    <= '0;
      selecao     <= 2'b11;
      mem_req     <= 1'b0;
      carrega_acc <= 1'b0;
      carrega_reg <= 1'b0;
      reg_end     <= '0;
      ula_op      <= '0;
      ocupado     <= 1'b0;
      parado      <= 1'b0;
      erro        <= 1'b0;
    end else begin
      estado <= estado_n;

      // Counter restarts whenever a fetch state is entered or left.
      if (busca_atual && (estado_n == estado)) cnt <= cnt + 1'b1;
      else                                     cnt <= '0;

      if (busca_atual && mem_ack) begin
        pc <= pc + 1'b1;
        if (estado == BUSCA) ir       <= mem_dado;
        else                 imediato <= mem_dado;
      end

      if (ilegal || timeout) erro <= 1'b1;

      mem_req     <= (estado_n == BUSCA) || (estado_n == BUSCA_IMED);
      ocupado     <= (estado_n != OCIOSO) && (estado_n != PARADO);
      parado      <= (estado_n == PARADO);
      selecao     <= sel_n;
      carrega_acc <= acc_n;
      carrega_reg <= reg_n;

      if ((estado_n == EXECUTA) || (estado_n == ESCRITA)) begin
        ula_op  <= ir[4:2];
        reg_end <= ir[1:0];
      end else begin
        ula_op  <= '0;
        reg_end <= '0;
      end
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: byte-wide memory model with programmable ack delay.
module tb_unidade_controle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iniciar;
  logic       mem_ack;
  logic [7:0] mem_dado;
  logic       mem_req;
  logic [7:0] mem_end;
  logic [1:0] selecao;
  logic [7:0] imediato;
  logic       carrega_acc, carrega_reg;
  logic [1:0] reg_end;
  logic [2:0] ula_op;
  logic       ocupado, parado, erro;

  logic [7:0] mem [256];
  int         ack_atraso;
  bit         ack_en;
  int         wcnt;
  int         checks = 0;
  int         errors = 0;

  unidade_controle #(.LARGURA_END(8), .TIMEOUT_CICLOS(15)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .mem_ack(mem_ack), .mem_dado(mem_dado),
    .mem_req(mem_req), .mem_end(mem_end), .selecao(selecao), .imediato(imediato),
    .carrega_acc(carrega_acc), .carrega_reg(carrega_reg), .reg_end(reg_end),
    .ula_op(ula_op), .ocupado(ocupado), .parado(parado), .erro(erro)
  );

  always #5 clk = ~clk;

  assign mem_dado = mem[mem_end];

  // Ack after ack_atraso wait cycles of mem_req; idle low otherwise.
  always @(negedge clk) begin
    if (mem_req && ack_en) begin
      mem_ack = (wcnt >= ack_atraso);
      wcnt++;
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; iniciar = 1'b0; ack_en = 1'b1; ack_atraso = 0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, mem_end, selecao, imediato, carrega_acc, carrega_reg, reg_end, ula_op,
         ocupado, parado, erro} !== {1'b0, 8'h00, 2'b11, 8'h00, 1'b0, 1'b0, 2'b00, 3'b000,
         1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: req=%b end=%h sel=%b imm=%h acc=%b reg=%b re=%b op=%b oc=%b pa=%b er=%b, required 0 00 11 00 0 0 00 000 0 0 0",
               mem_req, mem_end, selecao, imediato, carrega_acc, carrega_reg, reg_end, ula_op,
               ocupado, parado, erro);
    end
  endtask

  task automatic test_ldi();
    do_reset(); fill(8'hE0); mem[0] = 8'h20; mem[1] = 8'h5A;
    start();
    checks++;
    if ({mem_req, mem_end, ocupado} !== {1'b1, 8'h00, 1'b1}) begin
      errors++; $display("FAIL ldi_busca: req/end/oc=%b/%h/%b required 1/00/1", mem_req, mem_end, ocupado);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL ldi_req_falls: mem_req=%b required 0", mem_req);
    end
    tick();
    checks++;
    if ({mem_req, mem_end} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL ldi_busca_imed: req/end=%b/%h required 1/01", mem_req, mem_end);
    end
    tick();
    checks++;
    if ({selecao, imediato, carrega_acc, carrega_reg, mem_end} !== {2'b10, 8'h5A, 1'b1, 1'b0, 8'h02}) begin
      errors++;
      $display("FAIL ldi_escrita: sel=%b imm=%h acc=%b reg=%b pc=%h required 10 5a 1 0 02",
               selecao, imediato, carrega_acc, carrega_reg, mem_end);
    end
    tick();
    checks++;
    if ({carrega_acc, selecao, mem_req} !== {1'b0, 2'b11, 1'b1}) begin
      errors++; $display("FAIL ldi_pulse_end: acc=%b sel=%b req=%b required 0 11 1", carrega_acc, selecao, mem_req);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset(); fill(8'hE0); mem[0] = 8'h20; mem[1] = 8'h5A;
    start(); tick(); tick(); tick();
    checks++;
    if (carrega_acc !== 1'b1) begin
      errors++; $display("FAIL mid_escrita_reached: acc=%b required 1", carrega_acc);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({selecao, imediato, carrega_acc, mem_end, ocupado} !== {2'b11, 8'h00, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_escrita: sel=%b imm=%h acc=%b pc=%h oc=%b required 11 00 0 00 0",
               selecao, imediato, carrega_acc, mem_end, ocupado);
    end
    do_reset(); ack_en = 1'b0;
    start(); tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL async_reset_busca: mem_req=%b required 0", mem_req);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_late_ack();
    do_reset(); fill(8'hE0); mem[0] = 8'h6D; ack_atraso = 3;
    start(); tick(); tick(); tick();
    checks++;
    if ({mem_req, ocupado, parado} !== {1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL alu_wait4: req/oc/pa=%b/%b/%b required 1/1/0", mem_req, ocupado, parado);
    end
    tick(); tick();
    checks++;
    if ({ula_op, reg_end, selecao, carrega_acc} !== {3'b011, 2'b01, 2'b11, 1'b0}) begin
      errors++; $display("FAIL alu_executa: op=%b re=%b sel=%b acc=%b required 011 01 11 0", ula_op, reg_end, selecao, carrega_acc);
    end
    tick();
    checks++;
    if ({ula_op, reg_end, selecao, carrega_acc, carrega_reg} !== {3'b011, 2'b01, 2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL alu_escrita: op=%b re=%b sel=%b acc=%b reg=%b required 011 01 00 1 0",
               ula_op, reg_end, selecao, carrega_acc, carrega_reg);
    end
  endtask

  task automatic test_mov_str();
    do_reset(); fill(8'hE0); mem[0] = 8'h43;
    start(); tick(); tick(); tick();
    checks++;
    if ({selecao, reg_end, carrega_acc, carrega_reg} !== {2'b01, 2'b11, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mov_escrita: sel=%b re=%b acc=%b reg=%b required 01 11 1 0", selecao, reg_end, carrega_acc, carrega_reg);
    end
    do_reset(); fill(8'hE0); mem[0] = 8'h82;
    start(); tick(); tick(); tick();
    checks++;
    if ({carrega_reg, reg_end, selecao, carrega_acc} !== {1'b1, 2'b10, 2'b11, 1'b0}) begin
      errors++; $display("FAIL str_escrita: reg=%b re=%b sel=%b acc=%b required 1 10 11 0", carrega_reg, reg_end, selecao, carrega_acc);
    end
    tick();
    checks++;
    if (carrega_reg !== 1'b0) begin
      errors++; $display("FAIL str_pulse_end: reg=%b required 0", carrega_reg);
    end
  endtask

  task automatic test_halt_illegal();
    logic [7:0] ops [3];
    logic       exp_erro [3];
    ops[0] = 8'hE0; ops[1] = 8'hA0; ops[2] = 8'hC0;
    exp_erro[0] = 1'b0; exp_erro[1] = 1'b1; exp_erro[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_reset(); fill(ops[k]);
      start(); tick(); tick();
      checks++;
      if ({parado, erro, ocupado} !== {1'b1, exp_erro[k], 1'b0}) begin
        errors++; $display("FAIL halt_%h: pa/er/oc=%b/%b/%b required 1/%b/0", ops[k], parado, erro, ocupado, exp_erro[k]);
      end
      iniciar = 1'b1; tick(); tick(); tick(); iniciar = 1'b0;
      checks++;
      if ({parado, mem_req, ocupado, erro} !== {1'b1, 1'b0, 1'b0, exp_erro[k]}) begin
        errors++; $display("FAIL halt_absorb_%h: pa/req/oc/er=%b/%b/%b/%b required 1/0/0/%b", ops[k], parado, mem_req, ocupado, erro, exp_erro[k]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset(); fill(8'h00); ack_atraso = 14;
    start();
    repeat (14) tick();
    tick();
    checks++;
    if ({erro, parado, mem_req, mem_end} !== {1'b0, 1'b0, 1'b0, 8'h01}) begin
      errors++; $display("FAIL ack_wait15: er/pa/req/pc=%b/%b/%b/%h required 0/0/0/01", erro, parado, mem_req, mem_end);
    end
    do_reset(); ack_en = 1'b0;
    start();
    repeat (14) tick();
    checks++;
    if ({mem_req, parado, erro} !== {1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_wait15: req/pa/er=%b/%b/%b required 1/0/0", mem_req, parado, erro);
    end
    tick();
    checks++;
    if ({parado, erro, mem_req, ocupado} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_halt: pa/er/req/oc=%b/%b/%b/%b required 1/1/0/0", parado, erro, mem_req, ocupado);
    end
  endtask

  task automatic test_pc_wrap();
    bit achou = 1'b0;
    do_reset(); fill(8'h00);
    start();
    for (int n = 0; n < 600 && !achou; n++) begin
      if (mem_req && mem_end == 8'hFF) achou = 1'b1;
      else tick();
    end
    checks++;
    if (!achou) begin
      errors++; $display("FAIL wrap_reach_ff: pc=%h required ff within 600 cycles", mem_end);
    end
    tick();
    checks++;
    if ({mem_end, mem_req} !== {8'h00, 1'b0}) begin
      errors++; $display("FAIL wrap_pc: pc=%h req=%b required 00 0", mem_end, mem_req);
    end
    tick();
    checks++;
    if ({mem_end, mem_req, erro} !== {8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wrap_refetch: pc=%h req=%b er=%b required 00 1 0", mem_end, mem_req, erro);
    end
  endtask

  initial begin
    rst_n = 1'b0; iniciar = 1'b0; ack_en = 1'b1; ack_atraso = 0; wcnt = 0; mem_ack = 1'b0;
    fill(8'hE0);
    test_reset();
    test_ldi();
    test_reset_mid_op();
    test_alu_late_ack();
    test_mov_str();
    test_halt_illegal();
    test_timeout();
    test_pc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
